// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL/clock-domain consumers and pll_reset_sequencer.
// There is no valid/ready handshake: every signal is a level (ready is a status, not a strobe);
// lock_lost_clr is the only pulse and acts on the single edge where it is high.
interface pll_reset_sequencer_if;
    logic       pll_locked;
    logic       lock_lost_clr;
    logic       rst_out_n;
    logic       ready;
    logic       lock_lost;
    logic [7:0] lock_loss_count;
    logic       pll_resetb;

    modport master (
        output pll_locked, lock_lost_clr,
        input  rst_out_n, ready, lock_lost, lock_loss_count, pll_resetb
    );

    modport slave (
        input  pll_locked, lock_lost_clr,
        output rst_out_n, ready, lock_lost, lock_loss_count, pll_resetb
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Holds the PLL clock-domain reset until lock has been stable, then counts lock losses.
// Optional PLL watchdog (timeout -> pulse pll_resetb) is enabled by defining PLL_RST_WATCHDOG_EN.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES     = 1048576,
    parameter int PLL_RESET_CYCLES   = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    pll_reset_sequencer_if.slave  if_seq,
    output logic [2:0]            o_dbg_state
);

    localparam int MAX_QUAL  = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                               LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int MAX_WDOG  = (TIMEOUT_CYCLES > PLL_RESET_CYCLES) ?
                               TIMEOUT_CYCLES : PLL_RESET_CYCLES;
    localparam int MAX_CYC   = (MAX_QUAL > MAX_WDOG) ? MAX_QUAL : MAX_WDOG;
    localparam int CNT_W     = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);
`ifdef PLL_RST_WATCHDOG_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] PRST_LAST    = CNT_W'(PLL_RESET_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        S_WAIT_LOCK = 3'd0,
        S_STABLE    = 3'd1,
        S_HOLD      = 3'd2,
`ifdef PLL_RST_WATCHDOG_EN
        S_RUN       = 3'd3,
        S_PLL_RST   = 3'd4
`else
        S_RUN       = 3'd3
`endif
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lock_sync;
    logic                   w_loss;
    logic                   r_rst_out_n;
    logic                   r_ready;
    logic                   r_lock_lost;
    logic [7:0]             r_loss_cnt;

    // pll_locked comes from the PLL's own analogue lock detector, so it is asynchronous here.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], if_seq.pll_locked};
        end
    end

    assign w_lock_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_WAIT_LOCK: begin
                if (w_lock_sync) begin
                    w_state_nxt = S_STABLE;
                    w_cnt_nxt   = '0;
`ifdef PLL_RST_WATCHDOG_EN
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_state_nxt = S_PLL_RST;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
`else
                end else begin
                    w_cnt_nxt   = '0;
                end
`endif
            end
            S_STABLE: begin
                if (!w_lock_sync) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (!w_lock_sync) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            S_RUN: begin
                w_cnt_nxt = '0;
                if (!w_lock_sync) begin
                    w_state_nxt = S_WAIT_LOCK;
                end
            end
`ifdef PLL_RST_WATCHDOG_EN
            S_PLL_RST: begin
                if (r_cnt == PRST_LAST) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
`endif
            default: begin
                w_state_nxt = S_WAIT_LOCK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Only a drop while released counts; drops during qualification are just restarts.
    assign w_loss = (r_state == S_RUN) && !w_lock_sync;

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rst_out_n <= 1'b0;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
            r_loss_cnt  <= 8'd0;
        end else begin
            r_rst_out_n <= (w_state_nxt == S_RUN);
            r_ready     <= (w_state_nxt == S_RUN);
            if (w_loss) begin
                r_lock_lost <= 1'b1;
                if (if_seq.lock_lost_clr) begin
                    r_loss_cnt <= 8'd1;
                end else if (r_loss_cnt != 8'hFF) begin
                    r_loss_cnt <= r_loss_cnt + 8'd1;
                end
            end else if (if_seq.lock_lost_clr) begin
                r_lock_lost <= 1'b0;
                r_loss_cnt  <= 8'd0;
            end
        end
    end

`ifdef PLL_RST_WATCHDOG_EN
    logic r_pll_resetb;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pll_resetb <= 1'b1;
        end else begin
            r_pll_resetb <= (w_state_nxt != S_PLL_RST);
        end
    end

    assign if_seq.pll_resetb = r_pll_resetb;
`else
    assign if_seq.pll_resetb = 1'b1;
`endif

    assign if_seq.rst_out_n       = r_rst_out_n;
    assign if_seq.ready           = r_ready;
    assign if_seq.lock_lost       = r_lock_lost;
    assign if_seq.lock_loss_count = r_loss_cnt;
    assign o_dbg_state            = r_state;

endmodule
